// File: rtl/aes_sbox_canright_pipe.sv
// Pipelined multi-lane AES S-box (forward/inverse) on the Canright
// normal-basis GF(2^8) inversion, with valid/ready flow control.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous flush of every in-flight transaction
//   in_valid_i/o_ready  input handshake; op_i/data_i sampled on accept
//   out_valid_o/ready_i output handshake; data_o/op_o held while stalled
//   op_i/op_o           0 = SubBytes, 1 = InvSubBytes
//   data_i/data_o       NumLanes bytes, lane k at [8k+7:8k]

// One byte lane: datapath registers only; the shared control supplies
// per-stage load enables and the op bits at the two mux points.
module aes_sbox_canright_lane #(
  parameter int NumStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumStages-1:0] ld_i,
  input  logic                 op_in_i,   // op of the byte entering
  input  logic                 op_out_i,  // op of the byte at the output mux
  input  logic [7:0]           data_i,
  output logic [7:0]           data_o
);

  // Basis-change matrices; row 0 multiplies the input MSB.
  localparam logic [0:7][7:0] A2X = {8'h98, 8'hf3, 8'hf2, 8'h48, 8'h09, 8'h81, 8'ha9, 8'hff};
  localparam logic [0:7][7:0] X2A = {8'h64, 8'h78, 8'h6e, 8'h8c, 8'h68, 8'h29, 8'hde, 8'h60};
  localparam logic [0:7][7:0] X2S = {8'h58, 8'h2d, 8'h9e, 8'h0b, 8'hdc, 8'h04, 8'h03, 8'h24};
  localparam logic [0:7][7:0] S2X = {8'h8c, 8'h79, 8'h05, 8'heb, 8'h12, 8'h04, 8'h51, 8'h53};

  function automatic logic [7:0] mvm(logic [7:0] b, logic [0:7][7:0] m);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        c[i] = c[i] ^ (m[j][i] & b[7-j]);
    return c;
  endfunction

  // GF(2^2) in normal basis [W^2, W]
  function automatic logic [1:0] mul2(logic [1:0] g, logic [1:0] d);
    logic a, b, c;
    a = g[1] & d[1];
    b = (^g) & (^d);
    c = g[0] & d[0];
    return {a ^ b, c ^ b};
  endfunction
  function automatic logic [1:0] sclw2(logic [1:0] g);
    return {g[0], g[1] ^ g[0]};
  endfunction
  function automatic logic [1:0] sclw(logic [1:0] g);
    return {g[1] ^ g[0], g[1]};
  endfunction
  function automatic logic [1:0] sq2(logic [1:0] g);
    return {g[0], g[1]};
  endfunction

  // GF(2^4) in normal basis [alpha^8, alpha^2]
  function automatic logic [3:0] mul4(logic [3:0] g, logic [3:0] d);
    logic [1:0] a, b, c;
    a = mul2(g[3:2], d[3:2]);
    b = mul2(g[3:2] ^ g[1:0], d[3:2] ^ d[1:0]);
    c = mul2(g[1:0], d[1:0]);
    return {a ^ sclw2(b), c ^ sclw2(b)};
  endfunction
  function automatic logic [3:0] sqscl4(logic [3:0] g);
    return {sq2(g[3:2] ^ g[1:0]), sclw(sq2(g[1:0]))};
  endfunction
  function automatic logic [3:0] inv4(logic [3:0] g);
    logic [1:0] d;
    d = sq2(sclw2(sq2(g[3:2] ^ g[1:0])) ^ mul2(g[3:2], g[1:0]));
    return {mul2(d, g[1:0]), mul2(d, g[3:2])};
  endfunction

  // GF(2^8) inversion split at the 4-bit c^b operand so it can be registered
  function automatic logic [3:0] cb8(logic [7:0] g);
    return sqscl4(g[7:4] ^ g[3:0]) ^ mul4(g[7:4], g[3:0]);
  endfunction
  function automatic logic [7:0] tail8(logic [3:0] d, logic [7:0] g);
    return {mul4(d, g[3:0]), mul4(d, g[7:4])};
  endfunction

  logic [7:0] x, inv, y, out_q;

  assign x = op_in_i ? mvm(data_i ^ 8'h63, S2X) : mvm(data_i, A2X);

  if (NumStages == 1) begin : g_s1
    assign inv = tail8(inv4(cb8(x)), x);
  end else if (NumStages == 2) begin : g_s2
    logic [3:0] cb_q;
    logic [7:0] x_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cb_q <= '0;
        x_q  <= '0;
      end else if (ld_i[0]) begin
        cb_q <= cb8(x);
        x_q  <= x;
      end
    end
    assign inv = tail8(inv4(cb_q), x_q);
  end else begin : g_s3
    logic [7:0] x_q, x1_q;
    logic [3:0] d_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        x_q  <= '0;
        x1_q <= '0;
        d_q  <= '0;
      end else begin
        if (ld_i[0]) x_q <= x;
        if (ld_i[1]) begin
          d_q  <= inv4(cb8(x_q));
          x1_q <= x_q;
        end
      end
    end
    assign inv = tail8(d_q, x1_q);
  end

  assign y = op_out_i ? mvm(inv, X2A) : (mvm(inv, X2S) ^ 8'h63);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  out_q <= '0;
    else if (ld_i[NumStages-1])   out_q <= y;
  end

  assign data_o = out_q;

endmodule

module aes_sbox_canright_pipe #(
  parameter int NumLanes  = 4,
  parameter int NumStages = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  op_i,
  input  logic [8*NumLanes-1:0] data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*NumLanes-1:0] data_o,
  output logic                  op_o
);

  if (NumStages < 1 || NumStages > 3) begin : g_bad_stages
    $error("NumStages must be 1, 2 or 3");
  end
  if (NumLanes < 1 || NumLanes > 16) begin : g_bad_lanes
    $error("NumLanes must be in 1..16");
  end

  logic [NumStages-1:0] v_q, v_d, op_q, load, adv, ld;
  logic                 op_out;

  // load[s]: slot s can take new content this cycle. It is the OR of
  // out_ready and "some slot at or after s is empty", which avoids a
  // combinational loop through the ready chain.
  always_comb begin : p_ctrl
    logic chain;
    chain = out_ready_i;
    load  = '0;
    adv   = '0;
    ld    = '0;
    v_d   = v_q;
    for (int s = NumStages - 1; s >= 0; s--) begin
      chain   = chain | ~v_q[s];
      load[s] = chain;
    end
    adv[NumStages-1] = v_q[NumStages-1] & out_ready_i;
    for (int s = 0; s < NumStages - 1; s++) adv[s] = v_q[s] & load[s+1];
    ld[0]  = in_valid_i & load[0] & ~clear_i;
    v_d[0] = (in_valid_i & load[0]) | (v_q[0] & ~adv[0]);
    for (int s = 1; s < NumStages; s++) begin
      ld[s]  = adv[s-1] & ~clear_i;
      v_d[s] = adv[s-1] | (v_q[s] & ~adv[s]);
    end
    if (clear_i) v_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q  <= '0;
      op_q <= '0;
    end else begin
      v_q <= v_d;
      if (ld[0]) op_q[0] <= op_i;
      for (int s = 1; s < NumStages; s++)
        if (ld[s]) op_q[s] <= op_q[s-1];
    end
  end

  // Op seen by the output mux: the incoming op when the mux feeds the only
  // register, else the op held in the stage just before the output register.
  if (NumStages == 1) begin : g_op1
    assign op_out = op_i;
  end else begin : g_opn
    assign op_out = op_q[NumStages-2];
  end

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    aes_sbox_canright_lane #(.NumStages(NumStages)) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .ld_i     (ld),
      .op_in_i  (op_i),
      .op_out_i (op_out),
      .data_i   (data_i[8*l +: 8]),
      .data_o   (data_o[8*l +: 8])
    );
  end

  assign in_ready_o  = load[0];
  assign out_valid_o = v_q[NumStages-1];
  assign op_o        = op_q[NumStages-1];

endmodule

// File: tb/tb_aes_sbox_canright_pipe.sv
module tb_aes_sbox_canright_pipe;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        clear     [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        op_in     [3];
  logic [31:0] data_in   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [31:0] data_out  [3];
  logic        op_out    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_sbox_canright_pipe #(.NumLanes(NL), .NumStages(g + 1)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .op_i        (op_in[g]),
      .data_i      (data_in[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .data_o      (data_out[g]),
      .op_o        (op_out[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  fwd_t [256];
  logic [7:0]  inv_t [256];
  logic [31:0] cap   [256];
  logic [32:0] exp_q [$];   // {op, data}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: FIPS-197 S-box from GF(2^8) inverse (poly 0x11b) + affine map
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] model(logic [31:0] d, logic op);
    logic [31:0] r;
    for (int l = 0; l < NL; l++)
      r[8*l +: 8] = op ? inv_t[d[8*l +: 8]] : fwd_t[d[8*l +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sweep(int i);
    logic [31:0] r;
    for (int l = 0; l < NL; l++) r[8*l +: 8] = 8'((i + 64 * l) % 256);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single transaction: checks latency in edges, data and op.
  task automatic one_txn(input int k, input logic [31:0] d, input logic op,
                         input logic [31:0] exp_d, input string tag);
    int n;
    in_valid[k] = 1'b1; data_in[k] = d; op_in[k] = op; out_ready[k] = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready[k], 1);
    step();
    in_valid[k] = 1'b0;
    #1;
    n = 1;
    while (!out_valid[k] && n < 10) begin
      step(); #1; n++;
    end
    chk({tag, "_latency"}, n, k + 1);
    chk({tag, "_data"}, data_out[k], exp_d);
    chk({tag, "_op"}, op_out[k], op);
    step();
  endtask

  // pat 0: forward sweep, 1: inverse of captured forward results, 2: random
  task automatic run_stream(input int k, input int n, input int pat, input int rdy_pct);
    int sent, got, cyc;
    logic stall, so, cur_o, fresh;
    logic [31:0] sd, cur_d;
    logic [32:0] e;
    sent = 0; got = 0; cyc = 0; stall = 1'b0; fresh = 1'b1;
    sd = '0; so = 1'b0; cur_d = '0; cur_o = 1'b0;
    while ((sent < n || exp_q.size() > 0) && cyc < n * 20 + 50) begin
      if (sent < n && fresh) begin
        case (pat)
          0: begin cur_d = sweep(sent); cur_o = 1'b0; end
          1: begin cur_d = cap[sent];   cur_o = 1'b1; end
          default: begin cur_d = $urandom; cur_o = 1'($urandom_range(1)); end
        endcase
        fresh = 1'b0;
      end
      in_valid[k]  = (sent < n);
      data_in[k]   = cur_d;
      op_in[k]     = cur_o;
      out_ready[k] = ($urandom_range(99) < rdy_pct);
      #1;
      if (stall) begin
        chk("stall_valid", out_valid[k], 1);
        chk("stall_data", data_out[k], sd);
        chk("stall_op", op_out[k], so);
      end
      stall = out_valid[k] && !out_ready[k];
      sd = data_out[k]; so = op_out[k];
      if (out_valid[k] && out_ready[k]) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_output: observed %0h expected none", data_out[k]);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("stream_data", data_out[k], e[31:0]);
          chk("stream_op", op_out[k], e[32]);
          if (pat == 0 && got < 256) cap[got] = data_out[k];
          got++;
        end
      end
      if (in_valid[k] && in_ready[k]) begin
        exp_q.push_back(pat == 1 ? {1'b1, sweep(sent)} : {cur_o, model(cur_d, cur_o)});
        sent++;
        fresh = 1'b1;
      end
      step();
      cyc++;
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    chk("stream_drained", exp_q.size() + (n - sent), 0);
    if (rdy_pct == 100) chk("stream_rate", cyc, n + k + 1);
    exp_q.delete();
  endtask

  task automatic bp_test(input int k);
    int acc;
    logic [31:0] d;
    logic o;
    acc = 0;
    out_ready[k] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      d = $urandom; o = 1'($urandom_range(1));
      in_valid[k] = 1'b1; data_in[k] = d; op_in[k] = o;
      #1;
      if (in_ready[k]) begin
        acc++;
        exp_q.push_back({o, model(d, o)});
      end
      step();
    end
    in_valid[k] = 1'b0;
    #1;
    chk("bp_accepts", acc, k + 1);
    chk("bp_in_ready", in_ready[k], 0);
    chk("bp_out_valid", out_valid[k], 1);
    run_stream(k, 150, 2, 50);
  endtask

  task automatic flush_test(input int k);
    out_ready[k] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid[k] = 1'b1; data_in[k] = $urandom; op_in[k] = 1'($urandom_range(1));
      step();
    end
    clear[k] = 1'b1; in_valid[k] = 1'b1; data_in[k] = 32'hAAAA_AAAA; op_in[k] = 1'b0;
    #1;
    chk("flush_before", out_valid[k], 1);
    step();
    clear[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    #1;
    chk("flush_valid", out_valid[k], 0);
    chk("flush_in_ready", in_ready[k], 1);
    for (int c = 0; c < 4; c++) begin
      step(); #1;
      chk("flush_stale", out_valid[k], 0);
    end
    step();
    one_txn(k, 32'h0000_0000, 1'b0, 32'h6363_6363, "flush_new");
  endtask

  task automatic reset_test();
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b1; out_ready[k] = 1'b1; data_in[k] = $urandom; op_in[k] = 1'b0;
    end
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_data", data_out[k], 0);
      chk("rst_op", op_out[k], 0);
      chk("rst_in_ready", in_ready[k], 1);
      in_valid[k] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        chk("rst_rel_in_ready", in_ready[k], 1);
        chk("rst_rel_stale", out_valid[k], 0);
      end
      step(); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      clear[k] = 1'b0; in_valid[k] = 1'b0; op_in[k] = 1'b0;
      data_in[k] = '0; out_ready[k] = 1'b1;
    end
    build_tables();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", out_valid[k], 0);
      chk("reset_data", data_out[k], 0);
      chk("reset_op", op_out[k], 0);
      chk("reset_in_ready", in_ready[k], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 3; k++) begin
      one_txn(k, 32'h5301_00FF, 1'b0, 32'hED7C_6316, "fwd_vec");
      one_txn(k, 32'hED7C_6316, 1'b1, 32'h5301_00FF, "inv_vec");
    end

    for (int k = 0; k < 3; k++) begin
      run_stream(k, 256, 0, 100);
      run_stream(k, 256, 1, 100);
      run_stream(k, 100, 2, 100);
    end

    for (int k = 0; k < 3; k++) bp_test(k);
    for (int k = 0; k < 3; k++) flush_test(k);

    reset_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
